hub75_phy_arbiter: RTL and testbench

Two-port arbiter that shares the single HUB75 PHY output between the scan/shift engine (port 0) and an auxiliary requester (port 1), such as a driver-register init sequencer or a test-pattern generator. It grants the PHY to one requester at a time and forwards that requester's PHY signals through a registered mux. Between owners it drives a safe idle pattern for a programmable gap. It sits between the requesters and the PHY.

---
 rtl/hub75_phy_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_hub75_phy_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_phy_arbiter.sv
// hub75_phy_arbiter
// Shares one HUB75 PHY between the scan engine (port 0) and an auxiliary
// requester (port 1). Round-robin grant, a programmable idle gap between
// owners, a registered output mux, and an optional sticky over-hold flag.
module hub75_phy_arbiter #(
  parameter int N_BANKS    = 2,
  parameter int N_ROWS     = 32,
  parameter int N_CHANS    = 3,
  parameter int GAP_LEN    = 2,
  parameter int HOLD_MAX   = 0,
  parameter int SDW        = N_BANKS * N_CHANS,
  parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_0,
  output logic                  grant_0,
  input  logic                  p0_addr_inc,
  input  logic                  p0_addr_rst,
  input  logic                  p0_clk,
  input  logic                  p0_le,
  input  logic                  p0_blank,
  input  logic [LOG_N_ROWS-1:0] p0_addr,
  input  logic [SDW-1:0]        p0_data,

  input  logic                  req_1,
  output logic                  grant_1,
  input  logic                  p1_addr_inc,
  input  logic                  p1_addr_rst,
  input  logic                  p1_clk,
  input  logic                  p1_le,
  input  logic                  p1_blank,
  input  logic [LOG_N_ROWS-1:0] p1_addr,
  input  logic [SDW-1:0]        p1_data,

  output logic                  phy_addr_inc,
  output logic                  phy_addr_rst,
  output logic                  phy_clk,
  output logic                  phy_le,
  output logic                  phy_blank,
  output logic [LOG_N_ROWS-1:0] phy_addr,
  output logic [SDW-1:0]        phy_data,
  output logic                  err_hold
);

  localparam int GAP_W      = $clog2(GAP_LEN + 1);
  localparam int HOLD_W_RAW = $clog2(HOLD_MAX + 2);
  localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;

  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  state_t             arb_state;
  logic               last_reg, last_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic               err_next;
  logic               in_grant;
  logic               stay_granted;

  // Mux result before the output register
  logic                  mux_addr_inc, mux_addr_rst, mux_clk, mux_le, mux_blank;
  logic [LOG_N_ROWS-1:0] mux_addr;
  logic [SDW-1:0]        mux_data;

  // Round-robin pick among pending requests; contention goes to the port
  // that did not own the PHY last.
  always_comb begin
    arb_state = S_IDLE;
    if (req_0 && req_1) begin
      arb_state = last_reg ? S_GRANT0 : S_GRANT1;
    end else if (req_0) begin
      arb_state = S_GRANT0;
    end else if (req_1) begin
      arb_state = S_GRANT1;
    end
  end

  // Next-state logic: grant until the owner drops its request, then idle gap.
  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        state_next = arb_state;
      end
      S_GRANT0: begin
        if (!req_0) begin
          state_next   = S_GAP;
          last_next    = 1'b0;
          gap_cnt_next = GAP_LOAD;
        end
      end
      S_GRANT1: begin
        if (!req_1) begin
          state_next   = S_GAP;
          last_next    = 1'b1;
          gap_cnt_next = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg != '0) begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end else begin
          state_next = arb_state;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Hold counter counts completed grant cycles; the flag fires when the
  // count reaches the limit and the owner is keeping the grant for one more.
  always_comb begin
    in_grant      = (state_reg == S_GRANT0) || (state_reg == S_GRANT1);
    stay_granted  = in_grant && (state_next == state_reg);
    hold_cnt_next = '0;
    if (in_grant) begin
      hold_cnt_next = (hold_cnt_reg == HOLD_SAT) ? hold_cnt_reg
                                                 : hold_cnt_reg + HOLD_W'(1);
    end
    err_next = err_hold;
    if ((HOLD_MAX != 0) && stay_granted && (hold_cnt_next == HOLD_LIM)) begin
      err_next = 1'b1;
    end
  end

  // Output mux: current owner's PHY signals, otherwise the safe idle pattern.
  always_comb begin
    mux_addr_inc = 1'b0;
    mux_addr_rst = 1'b0;
    mux_clk      = 1'b0;
    mux_le       = 1'b0;
    mux_blank    = 1'b1;
    mux_addr     = '0;
    mux_data     = '0;
    case (state_reg)
      S_GRANT0: begin
        mux_addr_inc = p0_addr_inc;
        mux_addr_rst = p0_addr_rst;
        mux_clk      = p0_clk;
        mux_le       = p0_le;
        mux_blank    = p0_blank;
        mux_addr     = p0_addr;
        mux_data     = p0_data;
      end
      S_GRANT1: begin
        mux_addr_inc = p1_addr_inc;
        mux_addr_rst = p1_addr_rst;
        mux_clk      = p1_clk;
        mux_le       = p1_le;
        mux_blank    = p1_blank;
        mux_addr     = p1_addr;
        mux_data     = p1_data;
      end
      default: ;
    endcase
  end

  // Arbiter state, counters, grants and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      last_reg     <= 1'b0;
      gap_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      grant_0      <= 1'b0;
      grant_1      <= 1'b0;
      err_hold     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      gap_cnt_reg  <= gap_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_0      <= (state_next == S_GRANT0);
      grant_1      <= (state_next == S_GRANT1);
      err_hold     <= err_next;
    end
  end

  // Registered PHY outputs; reset forces the idle pattern at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phy_addr_inc <= 1'b0;
      phy_addr_rst <= 1'b0;
      phy_clk      <= 1'b0;
      phy_le       <= 1'b0;
      phy_blank    <= 1'b1;
      phy_addr     <= '0;
      phy_data     <= '0;
    end else begin
      phy_addr_inc <= mux_addr_inc;
      phy_addr_rst <= mux_addr_rst;
      phy_clk      <= mux_clk;
      phy_le       <= mux_le;
      phy_blank    <= mux_blank;
      phy_addr     <= mux_addr;
      phy_data     <= mux_data;
    end
  end

endmodule

// File: tb/tb_hub75_phy_arbiter.sv
// tb_hub75_phy_arbiter
// Directed stimulus pushes cycle-tagged expectations into a scoreboard; a
// negedge monitor pops and compares whatever is due in the current cycle.
module tb_hub75_phy_arbiter;

  localparam int SDW = 6;
  localparam int AW  = 5;

  localparam int SG0    = 0;
  localparam int SG1    = 1;
  localparam int SDATA  = 2;
  localparam int SBLANK = 3;
  localparam int SLE    = 4;
  localparam int SERR8  = 5;
  localparam int SERR0  = 6;
  localparam int SCLK   = 7;
  localparam int SADDR  = 8;
  localparam int SAINC  = 9;
  localparam int SARST  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           req_0, req_1;
  logic           p0_addr_inc, p0_addr_rst, p0_clk, p0_le, p0_blank;
  logic [AW-1:0]  p0_addr;
  logic [SDW-1:0] p0_data;
  logic           p1_addr_inc, p1_addr_rst, p1_clk, p1_le, p1_blank;
  logic [AW-1:0]  p1_addr;
  logic [SDW-1:0] p1_data;

  logic           grant_0, grant_1, err_hold;
  logic           phy_addr_inc, phy_addr_rst, phy_clk, phy_le, phy_blank;
  logic [AW-1:0]  phy_addr;
  logic [SDW-1:0] phy_data;

  logic           nh_grant_0, nh_grant_1, nh_err_hold;
  logic           nh_addr_inc, nh_addr_rst, nh_clk, nh_le, nh_blank;
  logic [AW-1:0]  nh_addr;
  logic [SDW-1:0] nh_data;

  hub75_phy_arbiter #(.N_BANKS(2), .N_ROWS(32), .N_CHANS(3), .GAP_LEN(2), .HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .grant_0(grant_0),
    .p0_addr_inc(p0_addr_inc), .p0_addr_rst(p0_addr_rst), .p0_clk(p0_clk),
    .p0_le(p0_le), .p0_blank(p0_blank), .p0_addr(p0_addr), .p0_data(p0_data),
    .req_1(req_1), .grant_1(grant_1),
    .p1_addr_inc(p1_addr_inc), .p1_addr_rst(p1_addr_rst), .p1_clk(p1_clk),
    .p1_le(p1_le), .p1_blank(p1_blank), .p1_addr(p1_addr), .p1_data(p1_data),
    .phy_addr_inc(phy_addr_inc), .phy_addr_rst(phy_addr_rst), .phy_clk(phy_clk),
    .phy_le(phy_le), .phy_blank(phy_blank), .phy_addr(phy_addr), .phy_data(phy_data),
    .err_hold(err_hold)
  );

  hub75_phy_arbiter #(.N_BANKS(2), .N_ROWS(32), .N_CHANS(3), .GAP_LEN(2), .HOLD_MAX(0)) dut_nh (
    .clk(clk), .rst(rst),
    .req_0(req_0), .grant_0(nh_grant_0),
    .p0_addr_inc(p0_addr_inc), .p0_addr_rst(p0_addr_rst), .p0_clk(p0_clk),
    .p0_le(p0_le), .p0_blank(p0_blank), .p0_addr(p0_addr), .p0_data(p0_data),
    .req_1(req_1), .grant_1(nh_grant_1),
    .p1_addr_inc(p1_addr_inc), .p1_addr_rst(p1_addr_rst), .p1_clk(p1_clk),
    .p1_le(p1_le), .p1_blank(p1_blank), .p1_addr(p1_addr), .p1_data(p1_data),
    .phy_addr_inc(nh_addr_inc), .phy_addr_rst(nh_addr_rst), .phy_clk(nh_clk),
    .phy_le(nh_le), .phy_blank(nh_blank), .phy_addr(nh_addr), .phy_data(nh_data),
    .err_hold(nh_err_hold)
  );

  typedef struct {
    int cyc;
    int sig;
    int exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Cycle counter: inputs driven #1 after a rising edge belong to cycle cyc.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      SG0:     return "grant_0";
      SG1:     return "grant_1";
      SDATA:   return "phy_data";
      SBLANK:  return "phy_blank";
      SLE:     return "phy_le";
      SERR8:   return "err_hold(hold8)";
      SERR0:   return "err_hold(hold0)";
      SCLK:    return "phy_clk";
      SADDR:   return "phy_addr";
      SAINC:   return "phy_addr_inc";
      SARST:   return "phy_addr_rst";
      default: return "unknown";
    endcase
  endfunction

  function automatic int actual(input int s);
    case (s)
      SG0:     return int'(grant_0);
      SG1:     return int'(grant_1);
      SDATA:   return int'(phy_data);
      SBLANK:  return int'(phy_blank);
      SLE:     return int'(phy_le);
      SERR8:   return int'(err_hold);
      SERR0:   return int'(nh_err_hold);
      SCLK:    return int'(phy_clk);
      SADDR:   return int'(phy_addr);
      SAINC:   return int'(phy_addr_inc);
      SARST:   return int'(phy_addr_rst);
      default: return -1;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle, away from the edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        int act;
        act = actual(sb[i].sig);
        checks++;
        if (act != sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc %0d got %0h want %0h", sig_name(sb[i].sig), cyc, act, sb[i].exp);
        end else begin
          $display("ok   %s cyc %0d = %0h", sig_name(sb[i].sig), cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int s, input int e);
    exp_t x;
    x.cyc = c;
    x.sig = s;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    req_0 = 1'b0; req_1 = 1'b0;
    p0_addr_inc = 1'b0; p0_addr_rst = 1'b0; p0_clk = 1'b0; p0_le = 1'b0; p0_blank = 1'b1;
    p0_addr = '0; p0_data = '0;
    p1_addr_inc = 1'b0; p1_addr_rst = 1'b0; p1_clk = 1'b0; p1_le = 1'b0; p1_blank = 1'b1;
    p1_addr = '0; p1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    goto(cyc + 2);
    rst = 1'b0;
  endtask

  task automatic random_px();
    p0_addr_inc = 1'b1; p0_addr_rst = 1'b1; p0_clk = 1'b1; p0_le = 1'b1; p0_blank = 1'b0;
    p0_addr = AW'($urandom_range(1, 31)); p0_data = SDW'($urandom_range(1, 63));
    p1_addr_inc = 1'b1; p1_addr_rst = 1'b1; p1_clk = 1'b1; p1_le = 1'b1; p1_blank = 1'b0;
    p1_addr = AW'($urandom_range(1, 31)); p1_data = SDW'($urandom_range(1, 63));
  endtask

  initial begin
    int b;
    idle_inputs();
    goto(2);

    // Reset value: 3 cycles of reset with random requester activity
    b = cyc;
    rst = 1'b1;
    req_0 = 1'b1; req_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_at(b + k, SG0, 0);    expect_at(b + k, SG1, 0);
      expect_at(b + k, SBLANK, 1); expect_at(b + k, SDATA, 0);
      expect_at(b + k, SLE, 0);    expect_at(b + k, SCLK, 0);
      expect_at(b + k, SADDR, 0);  expect_at(b + k, SAINC, 0);
      expect_at(b + k, SARST, 0);  expect_at(b + k, SERR8, 0);
    end
    for (int k = 0; k < 3; k++) begin
      goto(b + k);
      random_px();
    end
    goto(b + 3);
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (phy_blank !== 1'b1 || grant_0 !== 1'b0 || grant_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_exit cyc %0d got blank %0b g0 %0b g1 %0b want 1 0 0", cyc, phy_blank, grant_0, grant_1);
    end else begin
      $display("ok   reset_exit cyc %0d blank 1 grants 0", cyc);
    end

    // Single request, forwarding and gap
    b = cyc;
    p0_data = 6'h2A; p0_blank = 1'b0;
    expect_at(b + 10, SG0, 0);
    expect_at(b + 11, SG0, 1);   expect_at(b + 11, SDATA, 0);    expect_at(b + 11, SBLANK, 1);
    for (int c = 12; c <= 20; c++) begin
      expect_at(b + c, SG0, 1);  expect_at(b + c, SDATA, 'h2A);  expect_at(b + c, SBLANK, 0);
    end
    expect_at(b + 21, SG0, 0);   expect_at(b + 21, SDATA, 'h2A); expect_at(b + 21, SBLANK, 1);
    expect_at(b + 22, SDATA, 0); expect_at(b + 22, SBLANK, 1);
    expect_at(b + 23, SDATA, 0); expect_at(b + 23, SBLANK, 1);   expect_at(b + 23, SG1, 0);
    goto(b + 10); req_0 = 1'b1;
    goto(b + 20); req_0 = 1'b0; p0_blank = 1'b1;
    goto(b + 25);

    // Simultaneous requests, round robin, then a repeat contention
    do_reset();
    b = cyc;
    p0_data = 6'h33; p1_data = 6'h15; p0_blank = 1'b0; p1_blank = 1'b0;
    expect_at(b + 5, SG1, 0);
    expect_at(b + 6, SG1, 1);    expect_at(b + 6, SG0, 0);
    expect_at(b + 7, SDATA, 'h15);
    expect_at(b + 9, SG1, 1);
    expect_at(b + 10, SG1, 0);
    expect_at(b + 11, SG0, 0);   expect_at(b + 11, SDATA, 0);
    expect_at(b + 12, SG0, 1);   expect_at(b + 12, SDATA, 0);
    expect_at(b + 13, SDATA, 'h33);
    expect_at(b + 15, SG0, 1);
    expect_at(b + 16, SG0, 0);   expect_at(b + 16, SG1, 0);
    expect_at(b + 21, SG1, 1);   expect_at(b + 21, SG0, 0);
    expect_at(b + 23, SG1, 0);
    goto(b + 5);  req_0 = 1'b1; req_1 = 1'b1;
    goto(b + 9);  req_1 = 1'b0;
    goto(b + 15); req_0 = 1'b0;
    goto(b + 20); req_0 = 1'b1; req_1 = 1'b1;
    goto(b + 22); req_0 = 1'b0; req_1 = 1'b0;
    goto(b + 27);

    // Back-to-back handover straight from the gap
    do_reset();
    b = cyc;
    p0_data = 6'h0F; p1_data = 6'h30; p0_blank = 1'b0; p1_blank = 1'b0;
    expect_at(b + 3, SG0, 1);
    expect_at(b + 8, SG0, 1);
    expect_at(b + 9, SG0, 0);    expect_at(b + 9, SG1, 0);    expect_at(b + 9, SDATA, 'h0F);
    expect_at(b + 10, SG1, 0);   expect_at(b + 10, SDATA, 0); expect_at(b + 10, SBLANK, 1);
    expect_at(b + 11, SG1, 1);   expect_at(b + 11, SG0, 0);   expect_at(b + 11, SDATA, 0);
    expect_at(b + 12, SDATA, 'h30);
    expect_at(b + 14, SG1, 0);
    goto(b + 2);  req_0 = 1'b1;
    goto(b + 5);  req_1 = 1'b1;
    goto(b + 8);  req_0 = 1'b0;
    goto(b + 13); req_1 = 1'b0;
    goto(b + 17);

    // Hold check: 12-cycle grant against a limit of 8
    do_reset();
    b = cyc;
    expect_at(b + 10, SERR8, 0);
    expect_at(b + 11, SERR8, 1);
    expect_at(b + 12, SERR0, 0);
    expect_at(b + 13, SG0, 1);
    expect_at(b + 14, SG0, 1);
    expect_at(b + 15, SG0, 0);
    expect_at(b + 20, SERR8, 1);
    expect_at(b + 20, SERR0, 0);
    goto(b + 2);  req_0 = 1'b1;
    goto(b + 14); req_0 = 1'b0;
    goto(b + 21);
    checks++;
    if (err_hold !== 1'b1) begin
      errors++;
      $display("FAIL err_hold_sticky cyc %0d got %0b want 1", cyc, err_hold);
    end else begin
      $display("ok   err_hold_sticky cyc %0d = 1", cyc);
    end
    checks++;
    if (nh_err_hold !== 1'b0) begin
      errors++;
      $display("FAIL err_hold_disabled cyc %0d got %0b want 0", cyc, nh_err_hold);
    end else begin
      $display("ok   err_hold_disabled cyc %0d = 0", cyc);
    end

    // Reset pulsed in the middle of a port 1 grant
    do_reset();
    b = cyc;
    p1_le = 1'b1; p1_blank = 1'b0; p1_data = 6'h21;
    expect_at(b + 6, SG1, 1);   expect_at(b + 6, SLE, 1);   expect_at(b + 6, SBLANK, 0);
    expect_at(b + 7, SG1, 0);   expect_at(b + 7, SLE, 0);   expect_at(b + 7, SBLANK, 1);
    expect_at(b + 7, SDATA, 0);
    expect_at(b + 8, SG1, 0);
    expect_at(b + 9, SG1, 1);
    expect_at(b + 10, SLE, 1);  expect_at(b + 10, SDATA, 'h21);
    goto(b + 2);  req_1 = 1'b1;
    goto(b + 7);  rst = 1'b1;
    #1;
    checks++;
    if (phy_le !== 1'b0 || phy_blank !== 1'b1 || grant_1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset cyc %0d got le %0b blank %0b g1 %0b want 0 1 0", cyc, phy_le, phy_blank, grant_1);
    end else begin
      $display("ok   async_reset cyc %0d le 0 blank 1 g1 0", cyc);
    end
    goto(b + 8);  rst = 1'b0;
    goto(b + 11); req_1 = 1'b0; p1_le = 1'b0; p1_blank = 1'b1;
    goto(b + 15);

    // Anything still queued was never reached by the monitor
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s cyc %0d got none want %0h", sig_name(sb[0].sig), sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
